// File: rtl/pipe_ctr.sv
// rtl/pipe_ctr.sv - pipelined MIPS control: ID decode, ID/EX-EX/MEM-MEM/WB control registers, load-use stall, branch/jump kill.
// Optional jal support with link bits through every stage when PIPE_CTR_JAL_EN is defined.
module pipe_ctr #(
    parameter int REG_ADDR_W     = 5,
    parameter int ZERO_REG       = 0,
    parameter bit STALL_ON_STORE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            opCode,
    input  logic [REG_ADDR_W-1:0] idRs,
    input  logic [REG_ADDR_W-1:0] idRt,
    input  logic                  brTaken,
    output logic                  idJump,
    output logic                  stall,
    output logic                  flushIfId,
    output logic                  exRegDst,
    output logic                  exAluSrc,
    output logic                  exBranchEq,
    output logic                  exBranchNeq,
    output logic                  exMemRead,
    output logic                  exRegWrite,
    output logic [1:0]            exAluOp,
    output logic                  memRead,
    output logic                  memWrite,
    output logic                  memRegWrite,
    output logic                  memMemtoReg,
`ifdef PIPE_CTR_JAL_EN
    output logic                  exLink,
    output logic                  memLink,
    output logic                  wbLink,
`endif
    output logic                  wbRegWrite,
    output logic                  wbMemtoReg
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
`ifdef PIPE_CTR_JAL_EN
    localparam logic [5:0] OP_JAL  = 6'b000011;
`endif

    localparam logic [REG_ADDR_W-1:0] ZERO_IDX = REG_ADDR_W'(ZERO_REG);

    // Bundle order: regDst, jump, brEq, brNeq, memRead, memtoReg, memWrite, aluSrc, regWrite, aluOp[1:0]
    logic [10:0] dec;
    logic        is_sw;
    logic        is_jal;

    always_comb begin
        dec    = 11'b0;
        is_jal = 1'b0;
        case (opCode)
            OP_R:    dec = 11'b1000_0000_110;
            OP_J:    dec = 11'b0100_0000_000;
            OP_BEQ:  dec = 11'b0010_0000_001;
            OP_BNE:  dec = 11'b0001_0000_001;
            OP_ADDI: dec = 11'b0000_0001_100;
            OP_ANDI: dec = 11'b0000_0001_111;
            OP_LW:   dec = 11'b0000_1101_100;
            OP_SW:   dec = 11'b0000_0011_000;
`ifdef PIPE_CTR_JAL_EN
            OP_JAL: begin
                dec    = 11'b0100_0000_100;
                is_jal = 1'b1;
            end
`endif
            default: dec = 11'b0;
        endcase
    end

    assign is_sw = (opCode == OP_SW);

    // ID/EX register
    logic                  ex_reg_dst_q, ex_br_eq_q, ex_br_neq_q, ex_mem_read_q, ex_memto_reg_q;
    logic                  ex_mem_write_q, ex_alu_src_q, ex_reg_write_q;
    logic [1:0]            ex_alu_op_q;
    logic [REG_ADDR_W-1:0] ex_rt_q;
    // EX/MEM and MEM/WB registers
    logic                  mem_read_q, mem_write_q, mem_reg_write_q, mem_memto_reg_q;
    logic                  wb_reg_write_q, wb_memto_reg_q;

    logic                  ex_reg_dst_d, ex_br_eq_d, ex_br_neq_d, ex_mem_read_d, ex_memto_reg_d;
    logic                  ex_mem_write_d, ex_alu_src_d, ex_reg_write_d;
    logic [1:0]            ex_alu_op_d;
    logic [REG_ADDR_W-1:0] ex_rt_d;

    logic rt_hit;
    logic haz;
    logic bubble;

    // A store only consumes rt in MEM, so with STALL_ON_STORE=0 forwarding covers it.
    assign rt_hit = (ex_rt_q == idRt) && !(is_sw && !STALL_ON_STORE);
    assign haz    = ex_mem_read_q && (ex_rt_q != ZERO_IDX) && ((ex_rt_q == idRs) || rt_hit) && !is_jal;

    assign stall     = haz && !brTaken;
    assign idJump    = dec[9] && !brTaken;
    assign flushIfId = brTaken || (idJump && !stall);
    assign bubble    = stall || brTaken;

    always_comb begin
        ex_reg_dst_d   = dec[10];
        ex_br_eq_d     = dec[8];
        ex_br_neq_d    = dec[7];
        ex_mem_read_d  = dec[6];
        ex_memto_reg_d = dec[5];
        ex_mem_write_d = dec[4];
        ex_alu_src_d   = dec[3];
        ex_reg_write_d = dec[2];
        ex_alu_op_d    = dec[1:0];
        ex_rt_d        = idRt;
        if (bubble) begin
            ex_reg_dst_d   = 1'b0;
            ex_br_eq_d     = 1'b0;
            ex_br_neq_d    = 1'b0;
            ex_mem_read_d  = 1'b0;
            ex_memto_reg_d = 1'b0;
            ex_mem_write_d = 1'b0;
            ex_alu_src_d   = 1'b0;
            ex_reg_write_d = 1'b0;
            ex_alu_op_d    = 2'b00;
            ex_rt_d        = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_reg_dst_q    <= 1'b0;
            ex_br_eq_q      <= 1'b0;
            ex_br_neq_q     <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            ex_memto_reg_q  <= 1'b0;
            ex_mem_write_q  <= 1'b0;
            ex_alu_src_q    <= 1'b0;
            ex_reg_write_q  <= 1'b0;
            ex_alu_op_q     <= 2'b00;
            ex_rt_q         <= '0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_reg_write_q <= 1'b0;
            mem_memto_reg_q <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_memto_reg_q  <= 1'b0;
        end else begin
            ex_reg_dst_q    <= ex_reg_dst_d;
            ex_br_eq_q      <= ex_br_eq_d;
            ex_br_neq_q     <= ex_br_neq_d;
            ex_mem_read_q   <= ex_mem_read_d;
            ex_memto_reg_q  <= ex_memto_reg_d;
            ex_mem_write_q  <= ex_mem_write_d;
            ex_alu_src_q    <= ex_alu_src_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_alu_op_q     <= ex_alu_op_d;
            ex_rt_q         <= ex_rt_d;
            mem_read_q      <= ex_mem_read_q;
            mem_write_q     <= ex_mem_write_q;
            mem_reg_write_q <= ex_reg_write_q;
            mem_memto_reg_q <= ex_memto_reg_q;
            wb_reg_write_q  <= mem_reg_write_q;
            wb_memto_reg_q  <= mem_memto_reg_q;
        end
    end

`ifdef PIPE_CTR_JAL_EN
    logic ex_link_q, mem_link_q, wb_link_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_link_q  <= 1'b0;
            mem_link_q <= 1'b0;
            wb_link_q  <= 1'b0;
        end else begin
            ex_link_q  <= is_jal && !bubble;
            mem_link_q <= ex_link_q;
            wb_link_q  <= mem_link_q;
        end
    end

    assign exLink  = ex_link_q;
    assign memLink = mem_link_q;
    assign wbLink  = wb_link_q;
`endif

    assign exRegDst    = ex_reg_dst_q;
    assign exAluSrc    = ex_alu_src_q;
    assign exBranchEq  = ex_br_eq_q;
    assign exBranchNeq = ex_br_neq_q;
    assign exMemRead   = ex_mem_read_q;
    assign exRegWrite  = ex_reg_write_q;
    assign exAluOp     = ex_alu_op_q;
    assign memRead     = mem_read_q;
    assign memWrite    = mem_write_q;
    assign memRegWrite = mem_reg_write_q;
    assign memMemtoReg = mem_memto_reg_q;
    assign wbRegWrite  = wb_reg_write_q;
    assign wbMemtoReg  = wb_memto_reg_q;

endmodule

// File: tb/tb_pipe_ctr.sv
// tb/tb_pipe_ctr.sv - directed self-checking bench for pipe_ctr (link checks when PIPE_CTR_JAL_EN is defined).
module tb_pipe_ctr;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opCode;
    logic [4:0] idRs, idRt;
    logic       brTaken;

    logic idJump, stall, flushIfId;
    logic exRegDst, exAluSrc, exBranchEq, exBranchNeq, exMemRead, exRegWrite;
    logic [1:0] exAluOp;
    logic memRead, memWrite, memRegWrite, memMemtoReg, wbRegWrite, wbMemtoReg;

    logic n_idJump, n_stall, n_flushIfId;
    logic n_exRegDst, n_exAluSrc, n_exBranchEq, n_exBranchNeq, n_exMemRead, n_exRegWrite;
    logic [1:0] n_exAluOp;
    logic n_memRead, n_memWrite, n_memRegWrite, n_memMemtoReg, n_wbRegWrite, n_wbMemtoReg;
`ifdef PIPE_CTR_JAL_EN
    logic exLink, memLink, wbLink, n_exLink, n_memLink, n_wbLink;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_ctr dut (
        .clk(clk), .rst(rst), .opCode(opCode), .idRs(idRs), .idRt(idRt), .brTaken(brTaken),
        .idJump(idJump), .stall(stall), .flushIfId(flushIfId),
        .exRegDst(exRegDst), .exAluSrc(exAluSrc), .exBranchEq(exBranchEq), .exBranchNeq(exBranchNeq),
        .exMemRead(exMemRead), .exRegWrite(exRegWrite), .exAluOp(exAluOp),
        .memRead(memRead), .memWrite(memWrite), .memRegWrite(memRegWrite), .memMemtoReg(memMemtoReg),
`ifdef PIPE_CTR_JAL_EN
        .exLink(exLink), .memLink(memLink), .wbLink(wbLink),
`endif
        .wbRegWrite(wbRegWrite), .wbMemtoReg(wbMemtoReg)
    );

    pipe_ctr #(.STALL_ON_STORE(1'b0)) dut_ns (
        .clk(clk), .rst(rst), .opCode(opCode), .idRs(idRs), .idRt(idRt), .brTaken(brTaken),
        .idJump(n_idJump), .stall(n_stall), .flushIfId(n_flushIfId),
        .exRegDst(n_exRegDst), .exAluSrc(n_exAluSrc), .exBranchEq(n_exBranchEq), .exBranchNeq(n_exBranchNeq),
        .exMemRead(n_exMemRead), .exRegWrite(n_exRegWrite), .exAluOp(n_exAluOp),
        .memRead(n_memRead), .memWrite(n_memWrite), .memRegWrite(n_memRegWrite), .memMemtoReg(n_memMemtoReg),
`ifdef PIPE_CTR_JAL_EN
        .exLink(n_exLink), .memLink(n_memLink), .wbLink(n_wbLink),
`endif
        .wbRegWrite(n_wbRegWrite), .wbMemtoReg(n_wbMemtoReg)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic bt);
        opCode  = op;
        idRs    = rs;
        idRt    = rt;
        brTaken = bt;
        #1;
    endtask

    localparam logic [5:0] R = 6'b000000, J = 6'b000010, LW = 6'b100011, SW = 6'b101011, NOP = 6'b111111;

    logic [16:0] all_out;
    assign all_out = {idJump, stall, flushIfId, exRegDst, exAluSrc, exBranchEq, exBranchNeq,
                      exMemRead, exRegWrite, exAluOp, memRead, memWrite, memRegWrite,
                      memMemtoReg, wbRegWrite, wbMemtoReg};

    initial begin
        rst = 1'b1;
        drive(R, 5'd1, 5'd2, 1'b0);
        tick();
        tick();
        chk("reset_all_zero", 32'(all_out), 32'h0);

        // R-type flows EX -> MEM -> WB
        rst = 1'b0;
        drive(R, 5'd1, 5'd2, 1'b0);
        tick();
        chk("r_exRegDst", 32'(exRegDst), 32'd1);
        chk("r_exRegWrite", 32'(exRegWrite), 32'd1);
        chk("r_exAluOp", 32'(exAluOp), 32'd2);
        drive(NOP, 5'd0, 5'd0, 1'b0);
        tick();
        chk("r_memRegWrite", 32'(memRegWrite), 32'd1);
        chk("nop_exRegWrite", 32'(exRegWrite), 32'd0);
        tick();
        chk("r_wbRegWrite", 32'(wbRegWrite), 32'd1);

        // lw r8 then add using r8: one bubble
        drive(LW, 5'd0, 5'd8, 1'b0);
        tick();
        chk("lw_exMemRead", 32'(exMemRead), 32'd1);
        chk("lw_exAluSrc", 32'(exAluSrc), 32'd1);
        drive(R, 5'd8, 5'd3, 1'b0);
        chk("lu_stall", 32'(stall), 32'd1);
        chk("lu_flush", 32'(flushIfId), 32'd0);
        tick();
        chk("lu_bubble_regdst", 32'(exRegDst), 32'd0);
        chk("lu_bubble_regwr", 32'(exRegWrite), 32'd0);
        chk("lu_memRead", 32'(memRead), 32'd1);
        chk("lu_stall_drops", 32'(stall), 32'd0);
        tick();
        chk("lu_add_late_regdst", 32'(exRegDst), 32'd1);
        chk("lu_wbMemtoReg", 32'(wbMemtoReg), 32'd1);

        // zero register never hazards
        drive(LW, 5'd5, 5'd0, 1'b0);
        tick();
        drive(R, 5'd0, 5'd0, 1'b0);
        chk("zero_reg_stall", 32'(stall), 32'd0);
        tick();

        // store rt match: stalls only with STALL_ON_STORE=1
        drive(LW, 5'd1, 5'd9, 1'b0);
        tick();
        drive(SW, 5'd2, 5'd9, 1'b0);
        chk("sw_rt_stall_on", 32'(stall), 32'd1);
        chk("sw_rt_stall_off", 32'(n_stall), 32'd0);
        drive(SW, 5'd9, 5'd2, 1'b0);
        chk("sw_rs_stall_off", 32'(n_stall), 32'd1);
        tick();

        // branch taken beats load-use hazard
        drive(LW, 5'd0, 5'd7, 1'b0);
        tick();
        drive(LW, 5'd7, 5'd1, 1'b1);
        chk("br_haz_stall", 32'(stall), 32'd0);
        chk("br_haz_flush", 32'(flushIfId), 32'd1);
        tick();
        chk("br_kill_exMemRead", 32'(exMemRead), 32'd0);
        chk("br_kill_exRegWrite", 32'(exRegWrite), 32'd0);

        // jump decode and jump gated by branch
        drive(NOP, 5'd0, 5'd0, 1'b0);
        tick();
        drive(J, 5'd0, 5'd0, 1'b0);
        chk("j_idJump", 32'(idJump), 32'd1);
        chk("j_flush", 32'(flushIfId), 32'd1);
        drive(J, 5'd0, 5'd0, 1'b1);
        chk("j_br_idJump", 32'(idJump), 32'd0);
        chk("j_br_flush", 32'(flushIfId), 32'd1);
        tick();

        // jump while stalled waits, then flushes
        drive(LW, 5'd0, 5'd4, 1'b0);
        tick();
        drive(J, 5'd4, 5'd0, 1'b0);
        chk("js_stall", 32'(stall), 32'd1);
        chk("js_flush_held", 32'(flushIfId), 32'd0);
        tick();
        chk("js_stall_off", 32'(stall), 32'd0);
        chk("js_flush", 32'(flushIfId), 32'd1);
        tick();

        // store stream then mid-stream reset
        drive(SW, 5'd1, 5'd2, 1'b0);
        tick();
        tick();
        chk("sw_memWrite", 32'(memWrite), 32'd1);
        rst = 1'b1;
        tick();
        chk("rst_mid_memWrite", 32'(memWrite), 32'd0);
        chk("rst_mid_exAluSrc", 32'(exAluSrc), 32'd0);
        rst = 1'b0;

`ifdef PIPE_CTR_JAL_EN
        drive(6'b000011, 5'd0, 5'd0, 1'b0);
        chk("jal_idJump", 32'(idJump), 32'd1);
        tick();
        drive(NOP, 5'd0, 5'd0, 1'b0);
        tick();
        tick();
        chk("jal_wbLink", 32'(wbLink), 32'd1);
        chk("jal_wbRegWrite", 32'(wbRegWrite), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
